// File: rtl/memd_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state encoding,
// port indices, the two-requester picker and the read-return tag.
package memd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } pick_t;

  typedef struct packed {
    logic valid;
    logic tag;
  } rd_tag_t;

  // On a tie, round-robin hands the grant to the port that did not issue last;
  // fixed priority always favours port 0.
  function automatic pick_t pick_port(input logic req0, input logic req1,
                                      input logic fair, input logic last);
    pick_t p;
    p.valid = req0 | req1;
    if (req0 && req1) begin
      p.port = (fair && (last == PORT0)) ? PORT1 : PORT0;
    end else begin
      p.port = req1 ? PORT1 : PORT0;
    end
    return p;
  endfunction

  function automatic state_e own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/memd_arbiter_lock_cnt.sv
// Lock-duration counter: counts consecutive owned cycles under lock and is
// cleared whenever ownership is re-arbitrated.
module memd_arbiter_lock_cnt #(
  parameter int DATA_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [DATA_SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + DATA_SIZE'(1);
    end
  end

endmodule

// File: rtl/memd_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU controller on port 0,
// debug/host loader on port 1. One beat per cycle, optional bounded lock.
module memd_arbiter
  import memd_arbiter_pkg::*;
#(
  parameter int AWIDTH   = 7,
  parameter int DWIDTH   = 16,
  parameter int FAIR     = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out
);

  localparam int             CW        = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0]  LOCK_LAST = CW'(MAX_LOCK - 1);

  state_e            state_q, state_d;
  logic              last_q, last_eff;
  logic [CW-1:0]     lock_cnt;
  logic              cnt_inc, cnt_clr;
  rd_tag_t           rd_q, rd_d;
  logic [DWIDTH-1:0] rdata0_q, rdata1_q;
  pick_t             pick;

  logic              own_valid, owner, beat;
  logic              req_sel, we_sel, lock_sel, req_oth;
  logic [AWIDTH-1:0] addr_sel;
  logic [DWIDTH-1:0] wdata_sel;

  assign gnt0 = (state_q == ST_OWN0);
  assign gnt1 = (state_q == ST_OWN1);

  // Owner-side view of the request bundle.
  always_comb begin
    own_valid = (state_q != ST_IDLE);
    owner     = (state_q == ST_OWN1);
    req_sel   = owner ? req1   : req0;
    we_sel    = owner ? we1    : we0;
    lock_sel  = owner ? lock1  : lock0;
    addr_sel  = owner ? addr1  : addr0;
    wdata_sel = owner ? wdata1 : wdata0;
    req_oth   = owner ? req0   : req1;
  end

  assign beat        = own_valid & req_sel;
  assign mem_wr      = beat & we_sel;
  assign mem_rd      = beat & ~we_sel;
  assign mem_addr    = own_valid ? addr_sel  : '0;
  assign mem_data_in = own_valid ? wdata_sel : '0;

  // Re-arbitration in a beat cycle must already see this beat's port as last,
  // otherwise back-to-back round-robin would favour the same port twice.
  assign last_eff = beat ? owner : last_q;
  assign pick     = pick_port(req0, req1, FAIR != 0, last_eff);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = ST_IDLE;
    cnt_inc = 1'b0;
    cnt_clr = 1'b1;
    if (!own_valid) begin
      if (pick.valid) state_d = own_state(pick.port);
    end else if (lock_sel && req_sel && (lock_cnt < LOCK_LAST)) begin
      state_d = state_q;
      cnt_inc = 1'b1;
      cnt_clr = 1'b0;
    end else if (lock_sel && req_sel && req_oth) begin
      // Lock budget spent while the other port waits: hand over regardless of FAIR.
      state_d = own_state(~owner);
    end else if (pick.valid) begin
      state_d = own_state(pick.port);
    end
  end

  memd_arbiter_lock_cnt #(
    .DATA_SIZE(CW)
  ) u_lock_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (lock_cnt)
  );

  assign rd_d = '{valid: mem_rd, tag: owner};

  assign rvalid0 = rd_q.valid & (rd_q.tag == PORT0);
  assign rvalid1 = rd_q.valid & (rd_q.tag == PORT1);
  assign rdata0  = rvalid0 ? mem_data_out : rdata0_q;
  assign rdata1  = rvalid1 ? mem_data_out : rdata1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT1;
      rd_q     <= '0;
      // NOTE: the read-data holding registers are reset too, so rdata reads 0 after reset.
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      last_q  <= last_eff;
      rd_q    <= rd_d;
      if (rvalid0) rdata0_q <= mem_data_out;
      if (rvalid1) rdata1_q <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_memd_arbiter.sv
// Directed bench for memd_arbiter: a round-robin instance backed by a small
// memory model, plus a fixed-priority instance sharing the same requests.
module tb_memd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [6:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr, mem_rd;
  logic [15:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [6:0]  mem_addr;

  logic        gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, mem_wr_f, mem_rd_f;
  logic [15:0] rdata0_f, rdata1_f, mem_data_in_f;
  logic [6:0]  mem_addr_f;
  logic [15:0] fp_mem_data_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign fp_mem_data_out = 16'h0000;

  memd_arbiter #(.AWIDTH(7), .DWIDTH(16), .FAIR(1), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  memd_arbiter #(.AWIDTH(7), .DWIDTH(16), .FAIR(0), .MAX_LOCK(8)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_f), .gnt1(gnt1_f), .rvalid0(rvalid0_f), .rvalid1(rvalid1_f),
    .rdata0(rdata0_f), .rdata1(rdata1_f),
    .mem_wr(mem_wr_f), .mem_rd(mem_rd_f), .mem_addr(mem_addr_f),
    .mem_data_in(mem_data_in_f), .mem_data_out(fp_mem_data_out)
  );

  // Memory model: unwritten words read back as 16'hA000 | addr.
  logic [15:0]  mem [128];
  logic [127:0] wr_flag;

  always @(posedge clk) begin
    if (!rst) wr_flag <= '0;
    else if (mem_wr) begin
      mem[mem_addr]     <= mem_data_in;
      wr_flag[mem_addr] <= 1'b1;
    end
    if (mem_rd) mem_data_out <= wr_flag[mem_addr] ? mem[mem_addr] : (16'hA000 | {9'd0, mem_addr});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {30'd0, gnt0, gnt1}, 32'd0);
    check({tag, "_rv"}, {30'd0, rvalid0, rvalid1}, 32'd0);
    check({tag, "_mem"}, {14'd0, mem_wr, mem_rd, 9'd0, mem_addr}, 32'd0);
    check({tag, "_din"}, {16'd0, mem_data_in}, 32'd0);
    check({tag, "_rd"}, {rdata0, rdata1}, 32'd0);
    check({tag, "_fp"}, {26'd0, gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, mem_wr_f, mem_rd_f}
                        | {rdata0_f, rdata1_f} | {16'd0, mem_data_in_f} | {25'd0, mem_addr_f}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 7'd3; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 7'd4; wdata1 = '0;
    step();

    // Reset held with both ports requesting: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet($sformatf("rst%0d", i));
      step();
    end

    // Cycle 1 after release: still IDLE.
    rst = 1'b1;
    @(negedge clk);
    check("rel_c1_gnt", {gnt0, gnt1}, 2'b00);
    step();

    // Cycles 2..7: continuous reads on both ports alternate 0,1,0,1.
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("rr_c%0d_gnt", c), {gnt0, gnt1}, (c % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("rr_c%0d_addr", c), mem_addr, (c % 2 == 0) ? 7'd3 : 7'd4);
      check($sformatf("rr_c%0d_fp", c), {gnt0_f, gnt1_f}, 2'b10);
      if (c >= 3) begin
        check($sformatf("rr_c%0d_rv", c), {rvalid0, rvalid1}, (c % 2 == 1) ? 2'b10 : 2'b01);
        if (c % 2 == 1) check($sformatf("rr_c%0d_rd0", c), rdata0, 16'hA003);
        else            check($sformatf("rr_c%0d_rd1", c), rdata1, 16'hA004);
      end
      step();
    end

    // Cycle 8: grant without request issues nothing.
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("noreq_gnt", {gnt0, gnt1}, 2'b10);
    check("noreq_rd", mem_rd, 1'b0);
    check("noreq_rv1", {rvalid1, rdata1}, {1'b1, 16'hA004});
    step();

    // Cycle 9: IDLE again; port 0 raises a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'd5; wdata0 = 16'hBEEF;
    @(negedge clk);
    check("idle_gnt", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b0000);
    check("idle_rv", {rvalid0, rvalid1, mem_wr}, 3'b000);
    step();

    // Cycle 10: write beat; port 1 queues a read of the same address.
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'd5;
    @(negedge clk);
    check("wr_ctl", {gnt0, mem_wr, mem_rd}, 3'b110);
    check("wr_bus", {mem_addr, mem_data_in}, {7'd5, 16'hBEEF});
    step();

    // Cycle 11: read beat from port 1.
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    check("rd_ctl", {gnt1, mem_rd, mem_wr}, 3'b110);
    check("rd_addr", mem_addr, 7'd5);
    step();

    // Cycle 12: read data returns to port 1.
    req1 = 1'b0;
    @(negedge clk);
    check("rd_ret", {rvalid0, rvalid1, rdata1}, {2'b01, 16'hBEEF});
    step();

    // Cycle 13: data held, idle; port 0 starts a locked burst against port 1.
    req0 = 1'b1; lock0 = 1'b1; addr0 = 7'd6;
    req1 = 1'b1; lock1 = 1'b0; addr1 = 7'd7;
    @(negedge clk);
    check("hold_rd1", {rvalid1, rdata1}, {1'b0, 16'hBEEF});
    check("hold_gnt", {gnt0, gnt1}, 2'b00);
    step();

    // Cycles 14..21: eight owned cycles under lock.
    for (int c = 14; c <= 21; c++) begin
      @(negedge clk);
      check($sformatf("lk_c%0d_gnt", c), {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b1010);
      if (c == 15) check("lk_rv0", {rvalid0, rdata0}, {1'b1, 16'hA006});
      step();
    end

    // Cycle 22: forced hand-over on both instances.
    @(negedge clk);
    check("lk_handover", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b0101);
    step();

    // Cycles 23..25: plain contention; round-robin alternates, fixed keeps port 0.
    lock0 = 1'b0;
    @(negedge clk);
    check("tie_c23", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b1010);
    step();
    @(negedge clk);
    check("tie_c24", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b0110);
    step();
    @(negedge clk);
    check("tie_c25", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b1010);
    check("tie_c25_rv1", {rvalid1, rdata1}, {1'b1, 16'hA007});
    step();

    // Cycle 26: requests drop; port 1 owns but issues nothing.
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("drop_gnt", {gnt0, gnt1, mem_rd}, 3'b010);
    check("drop_rv0", {rvalid0, rdata0}, {1'b1, 16'hA006});
    step();

    // Cycle 27: idle; port 0 requests a read.
    req0 = 1'b1; addr0 = 7'd9;
    @(negedge clk);
    check("pre_rst_idle", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b0000);
    step();

    // Cycle 28: read beat, and reset is sampled at the end of this cycle.
    @(negedge clk);
    check("pre_rst_beat", {gnt0, mem_rd, mem_addr}, {2'b11, 7'd9});
    rst = 1'b0;
    step();

    // Cycle 29: the in-flight read is dropped; a tie is presented.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr1 = 7'd10;
    @(negedge clk);
    check("post_rst_rv", {rvalid0, rvalid1}, 2'b00);
    check("post_rst_rd", {rdata0, rdata1}, 32'd0);
    check("post_rst_gnt", {gnt0, gnt1}, 2'b00);
    step();

    // Cycle 30: last restored to 1, so port 0 wins the first tie.
    @(negedge clk);
    check("post_rst_tie", {gnt0, gnt1, gnt0_f, gnt1_f}, 4'b1010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
